// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a framed byte packet (length, big-endian
// words, XOR checksum), writes one word per four bytes, and enables fetch on success.
module imem_loader #(
  parameter int MEM_BYTES = 20,
  parameter int ADDR_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              run,
  output logic              load_done,
  output logic              load_err,
  output logic [15:0]       words_loaded
);

  // state   | meaning
  // IDLE    | no load since reset, waiting for start
  // LEN_HI  | expecting word-count high byte
  // LEN_LO  | expecting word-count low byte, range check
  // DATA    | assembling instruction words
  // CHK     | expecting checksum byte
  // DONE    | load good, fetch enabled, waiting for start
  // ERR     | load failed, fetch held, waiting for start
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHK, S_DONE, S_ERR
  } state_t;

  localparam logic [15:0] MAX_WORDS = 16'(MEM_BYTES / 4);

  state_t            state_q, state_d;
  logic [15:0]       len_q;
  logic [23:0]       word_q;
  logic [1:0]        byte_cnt;
  logic [7:0]        xor_q;
  logic [ADDR_W-1:0] wr_addr;
  logic              accept;
  logic              waiting;
  logic              last_word;
  logic [15:0]       len_full;

  assign byte_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                      (state_q == S_DATA)   || (state_q == S_CHK);
  assign waiting    = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);
  assign accept     = byte_valid && byte_ready;
  assign len_full   = {len_q[15:8], byte_data};
  assign last_word  = (byte_cnt == 2'd3) && ((words_loaded + 16'd1) == len_q);

  assign run       = (state_q == S_DONE);
  assign load_done = (state_q == S_DONE);
  assign load_err  = (state_q == S_ERR);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start) state_d = S_LEN_HI;
      S_LEN_HI: if (accept) state_d = S_LEN_LO;
      S_LEN_LO: begin
        if (accept) begin
          if (len_full > MAX_WORDS)  state_d = S_ERR;
          else if (len_full == 16'd0) state_d = S_CHK;
          else                        state_d = S_DATA;
        end
      end
      S_DATA: if (accept && last_word) state_d = S_CHK;
      S_CHK: begin
        if (accept) state_d = (byte_data == xor_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Write register is separate from word_q so the next word can stream in
  // while the previous write strobe is still out.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q        <= '0;
      word_q       <= '0;
      byte_cnt     <= '0;
      xor_q        <= '0;
      wr_addr      <= '0;
      words_loaded <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      mem_we <= 1'b0;
      if (waiting && start) begin
        byte_cnt     <= '0;
        xor_q        <= '0;
        wr_addr      <= '0;
        words_loaded <= '0;
      end
      if (accept) begin
        case (state_q)
          S_LEN_HI: begin
            len_q[15:8] <= byte_data;
            xor_q       <= xor_q ^ byte_data;
          end
          S_LEN_LO: begin
            len_q[7:0] <= byte_data;
            xor_q      <= xor_q ^ byte_data;
          end
          S_DATA: begin
            xor_q    <= xor_q ^ byte_data;
            word_q   <= {word_q[15:0], byte_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              mem_we       <= 1'b1;
              mem_wdata    <= {word_q, byte_data};
              mem_addr     <= wr_addr;
              wr_addr      <= wr_addr + ADDR_W'(4);
              words_loaded <= words_loaded + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of packets with expected writes and
// result, plus hand sequences for write timing and reset mid-load.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst, start, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, mem_we, run, load_done, load_err;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [15:0] words_loaded;

  int checks = 0;
  int errors = 0;

  imem_loader #(.MEM_BYTES(20), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .run(run),
    .load_done(load_done), .load_err(load_err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          off;
    int          len;
    int          wr_off;
    int          nwr;
    logic        done;
    logic        err;
    logic [15:0] words;
    logic        gaps;
  } vec_t;

  logic [7:0]  pool[$];
  logic [31:0] wpool[$];
  vec_t        vecs[6];
  logic [4:0]  wa_q[$];
  logic [31:0] wd_q[$];

  always @(negedge clk) begin
    if (!rst && mem_we) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_we"},    32'(mem_we), 32'd0);
    chk({tag, "_addr"},  32'(mem_addr), 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_run"},   32'(run), 32'd0);
    chk({tag, "_done"},  32'(load_done), 32'd0);
    chk({tag, "_err"},   32'(load_err), 32'd0);
    chk({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  task automatic send_vec(input int vi);
    vec_t v;
    int   i;
    int   budget;
    logic rdy;
    v = vecs[vi];
    wa_q.delete();
    wd_q.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk($sformatf("v%0d_ready_after_start", vi), 32'(byte_ready), 32'd1);
    chk($sformatf("v%0d_cleared_run", vi), 32'(run), 32'd0);
    i = 0;
    budget = 300;
    while (i < v.len && budget > 0) begin
      if (v.gaps && ($urandom_range(0, 1) == 0)) begin
        byte_valid = 1'b0;
        start      = ($urandom_range(0, 2) == 0);
      end else begin
        byte_valid = 1'b1;
        byte_data  = pool[v.off + i];
        start      = 1'b0;
      end
      rdy = byte_ready;
      @(negedge clk);
      if (byte_valid && rdy) i++;
      budget--;
    end
    byte_valid = 1'b0;
    start      = 1'b0;
    chk($sformatf("v%0d_bytes_accepted", vi), 32'(i), 32'(v.len));
    chk($sformatf("v%0d_run", vi),   32'(run), 32'(v.done));
    chk($sformatf("v%0d_done", vi),  32'(load_done), 32'(v.done));
    chk($sformatf("v%0d_err", vi),   32'(load_err), 32'(v.err));
    chk($sformatf("v%0d_words", vi), 32'(words_loaded), 32'(v.words));
    chk($sformatf("v%0d_ready_end", vi), 32'(byte_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk($sformatf("v%0d_run_hold", vi), 32'(run), 32'(v.done));
    chk($sformatf("v%0d_err_hold", vi), 32'(load_err), 32'(v.err));
    chk($sformatf("v%0d_nwrites", vi), 32'(wa_q.size()), 32'(v.nwr));
    for (int k = 0; k < v.nwr && k < wa_q.size(); k++) begin
      chk($sformatf("v%0d_addr%0d", vi, k), 32'(wa_q[k]), 32'(4 * k));
      chk($sformatf("v%0d_data%0d", vi, k), wd_q[k], wpool[v.wr_off + k]);
    end
  endtask

  initial begin
    pool = {8'h00, 8'h05,
            8'h08, 8'h41, 8'h00, 8'h02, 8'h00, 8'h21, 8'h30, 8'h02,
            8'h0C, 8'h26, 8'h00, 8'h02, 8'h00, 8'hE6, 8'h40, 8'h00,
            8'h05, 8'h49, 8'h00, 8'h16, 8'h89,
            8'h00, 8'h06,
            8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h24,
            8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23,
            8'h00, 8'h00, 8'h00};
    wpool = {32'h08410002, 32'h00213002, 32'h0C260002, 32'h00E64000,
             32'h05490016, 32'hDEADBEEF};
    //          off len wr  nwr done err words gaps
    vecs[0] = '{0,  23, 0,  5,  1'b1, 1'b0, 16'd5, 1'b0};
    vecs[1] = '{23, 2,  0,  0,  1'b0, 1'b1, 16'd0, 1'b0};
    vecs[2] = '{25, 7,  5,  1,  1'b0, 1'b1, 16'd1, 1'b0};
    vecs[3] = '{32, 7,  5,  1,  1'b1, 1'b0, 16'd1, 1'b0};
    vecs[4] = '{39, 3,  0,  0,  1'b1, 1'b0, 16'd0, 1'b0};
    vecs[5] = '{0,  23, 0,  5,  1'b1, 1'b0, 16'd5, 1'b1};

    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(byte_ready), 32'd0);

    for (int vi = 0; vi < 6; vi++) send_vec(vi);

    // Write strobe timing, then reset after nine data bytes with start in the same cycle.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; byte_valid = 1'b1;
    for (int j = 0; j < 11; j++) begin
      byte_data = pool[j];
      @(negedge clk);
      if (j == 5) begin
        chk("seq_we_pulse", 32'(mem_we), 32'd1);
        chk("seq_we_addr", 32'(mem_addr), 32'd0);
        chk("seq_we_data", mem_wdata, 32'h08410002);
        chk("seq_words_inc", 32'(words_loaded), 32'd1);
      end
      if (j == 6) chk("seq_we_single", 32'(mem_we), 32'd0);
    end
    chk("seq_words_mid", 32'(words_loaded), 32'd2);
    byte_valid = 1'b0;
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    chk_idle_outputs("midrst");
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("midrst_stays_idle", 32'(byte_ready), 32'd0);
    send_vec(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream loader that fills the fetch stage's byte-addressed instruction memory before execution starts. It accepts a framed packet over a valid/ready byte interface: a 16-bit word count, the instruction words, and an XOR checksum. It assembles big-endian 32-bit words and issues one word write per four bytes. It holds `run` low until a load completes cleanly; `run` drives the fetch stage's PC-advance enable.

## Interface
Parameters:
- `MEM_BYTES`, 20: instruction memory size in bytes; must be a multiple of 4.
- `ADDR_W`, 5: byte-address width; 2^ADDR_W ≥ MEM_BYTES.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  one-cycle pulse that begins a load.
- `byte_valid`  in  1  producer has a byte.
- `byte_data`  in  8  byte payload.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  one-cycle word write strobe.
- `mem_addr`  out  ADDR_W  byte address of the written word; always a multiple of 4.
- `mem_wdata`  out  32  word; bits [31:24] go to `mem_addr`, [7:0] go to `mem_addr`+3.
- `run`  out  1  fetch enable; 1 only after a successful load.
- `load_done`  out  1  level; last load succeeded.
- `load_err`  out  1  level; last load failed.
- `words_loaded`  out  16  count of words written in the current or last load.

## Operation
- Packet byte order: LEN_HI, LEN_LO, N×4 data bytes (MSB first per word), CHK.
- CHK is valid when it equals the XOR of every preceding packet byte, including both length bytes.
- A byte is accepted on a cycle where `byte_valid && byte_ready`.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERR.
- IDLE, DONE, ERR: `byte_ready`=0. A `start` pulse moves to LEN_HI; clears `run`, `load_done`, `load_err`, `words_loaded`, the byte-in-word counter, the write address and the running XOR.
- `start` is ignored in LEN_HI, LEN_LO, DATA and CHK.
- LEN_HI, LEN_LO, DATA, CHK: `byte_ready`=1.
- LEN_HI: latch N[15:8] → LEN_LO.
- LEN_LO: latch N[7:0].
  - If N > MEM_BYTES/4 → ERR.
  - Else if N=0 → CHK.
  - Else → DATA.
- DATA: shift each byte into the word register. On the 4th byte:
  - Register the write: `mem_we`=1 on the next cycle, with `mem_wdata`=word and `mem_addr`=4×`words_loaded`.
  - `words_loaded` increments in that same cycle.
  - After word N is accepted, go to CHK.
- A byte accepted in the same cycle as a pending `mem_we` is legal; the word register is separate from the write register.
- CHK: compare the accepted byte with the running XOR.
  - Match → DONE: `load_done`=1, `run`=1.
  - Mismatch → ERR: `load_err`=1, `run`=0.
- Writes already issued are not undone on error.
- Address arithmetic is ADDR_W bits. The length check guarantees no wrap; any write at or beyond MEM_BYTES is a design error.

## Timing
- Reset values: state IDLE, `byte_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `run`=0, `load_done`=0, `load_err`=0, `words_loaded`=0.
- `start` at cycle t → `byte_ready`=1 at t+1.
- The 4th byte of a word is accepted at cycle t → `mem_we` is high for exactly cycle t+1.
- The CHK byte is accepted at cycle t → `run`/`load_done` or `load_err` is high from t+1 and holds until the next `start` or `rst`.
- Backpressure: `byte_valid` gaps of any length stall the FSM without state change.
- `rst` mid-load: all outputs return to reset values on the next edge. Memory contents written so far persist.
- `start` and `rst` in the same cycle: `rst` wins.

## Test plan
- Load N=5 with bytes 00 05, then 08 41 00 02 00 21 30 02 0C 26 00 02 00 E6 40 00 05 49 00 16, then CHK 89 (valid every cycle).
  - Required: five `mem_we` pulses at addr 0/4/8/12/16 with data 08410002, 00213002, 0C260002, 00E64000, 05490016.
  - Required: `run`=1 and `load_done`=1 one cycle after the 89 byte; `words_loaded`=5.
- Oversize: 00 06.
  - Required: ERR after LEN_LO; `load_err`=1, `byte_ready`=0, no `mem_we`, `run`=0.
- Bad checksum: 00 01 DE AD BE EF 24 (correct CHK is 23).
  - Required: one `mem_we` with addr 0 and data DEADBEEF, then `load_err`=1 and `run`=0.
  - Then `start` and resend with CHK 23 → `run`=1.
- Zero length: 00 00 00.
  - Required: no `mem_we`; `load_done`=1, `run`=1, `words_loaded`=0.
- Backpressure: repeat the first scenario with `byte_valid` toggling 1/0 randomly.
  - Required: identical writes and result; `start` pulses mid-load are ignored.
- Reset mid-load: assert `rst` after 9 data bytes.
  - Required: all outputs at reset values next cycle, FSM in IDLE, `byte_ready`=0.
  - Then a fresh load succeeds.
